pdm_capture_ctrl: RTL and testbench

Sequencer for the PDM microphone front end of the PCM audio path. Generates the gated microphone clock, samples the 1-bit PDM stream, decimates it by boxcar ones-counting into PCM samples, discards mic start-up samples, and buffers results in a small FIFO with a valid/ready output. Sits between the mic pins and the PCM audio consumer, under start/stop control from the game core.

---
 rtl/pdm_cap_pkg.sv | 25 ++
 rtl/pdm_cap_fifo.sv | 77 +++++++
 rtl/pdm_capture_ctrl.sv | 164 ++++++++++++++++
 tb/tb_pdm_capture_ctrl.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/pdm_cap_pkg.sv
// Shared types and helpers for the PDM capture path: FSM state encoding,
// default parameter values and width helpers.
package pdm_cap_pkg;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_WARMUP,
      ST_RUN
   } state_e;

   localparam int unsigned DEF_HALF_PERIOD = 13;
   localparam int unsigned DEF_DECIM       = 64;
   localparam int unsigned DEF_WARMUP      = 4;
   localparam int unsigned DEF_FIFO_DEPTH  = 4;

   // Ones count spans 0..decim inclusive, hence one bit more than log2(decim).
   function automatic int unsigned pcm_width(input int unsigned decim);
      return $clog2(decim) + 1;
   endfunction

   function automatic int unsigned cnt_width(input int unsigned n);
      return (n < 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/pdm_cap_fifo.sv
// Small synchronous FIFO with a registered head/valid output; a push into a
// full FIFO succeeds only when a pop happens in the same cycle.
module pdm_cap_fifo
   import pdm_cap_pkg::*;
#(
   parameter int unsigned DEPTH = 4,
   parameter int unsigned W     = 8
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         push_i,
   input  logic [W-1:0] push_data_i,
   output logic         full_o,
   input  logic         pop_i,
   output logic [W-1:0] head_o,
   output logic         valid_o
);
   localparam int unsigned AW = cnt_width(DEPTH);
   localparam int unsigned CW = $clog2(DEPTH + 1);

   logic [W-1:0]  mem_q [DEPTH];
   logic [AW-1:0] rd_q, rd_d, wr_q, wr_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [W-1:0]  head_q, head_d;
   logic          valid_q;
   logic          do_pop, wr_en;

   assign full_o  = (cnt_q == CW'(DEPTH));
   assign do_pop  = pop_i && valid_q;
   assign wr_en   = push_i && (!full_o || do_pop);
   assign head_o  = head_q;
   assign valid_o = valid_q;

   always_comb begin
      // NOTE: every variable gets a default before any branch so no latch is inferred.
      rd_d   = do_pop ? rd_q + 1'b1 : rd_q;
      wr_d   = wr_en ? wr_q + 1'b1 : wr_q;
      cnt_d  = cnt_q;
      head_d = head_q;
      if (wr_en && !do_pop) begin
         cnt_d = cnt_q + 1'b1;
      end else if (!wr_en && do_pop) begin
         cnt_d = cnt_q - 1'b1;
      end
      // Bypass when the incoming word becomes the new head in the same cycle.
      if (wr_en && (wr_q == rd_d)) begin
         head_d = push_data_i;
      end else if (do_pop && (cnt_d != '0)) begin
         head_d = mem_q[rd_d];
      end
   end

   always_ff @(posedge clk) begin
      // NOTE: non-blocking assignments so all registers sample their inputs at the same edge.
      if (reset) begin
         rd_q    <= '0;
         wr_q    <= '0;
         cnt_q   <= '0;
         head_q  <= '0;
         valid_q <= 1'b0;
      end else begin
         rd_q    <= rd_d;
         wr_q    <= wr_d;
         cnt_q   <= cnt_d;
         head_q  <= head_d;
         valid_q <= (cnt_d != '0);
      end
   end

   // NOTE: storage is not reset; emptiness is defined by the pointers and count alone.
   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem_q[wr_q] <= push_data_i;
      end
   end

endmodule

// File: rtl/pdm_capture_ctrl.sv
// PDM microphone capture sequencer: gated mic clock, boxcar decimation, warm-up
// discard and output FIFO. Define PDM_CAP_SIGNED_OUT_EN for zero-centred samples.
module pdm_capture_ctrl
   import pdm_cap_pkg::*;
#(
   parameter int unsigned HALF_PERIOD = DEF_HALF_PERIOD,
   parameter int unsigned DECIM       = DEF_DECIM,
   parameter int unsigned WARMUP      = DEF_WARMUP,
   parameter int unsigned FIFO_DEPTH  = DEF_FIFO_DEPTH,
   parameter int unsigned PCM_W       = pcm_width(DECIM)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic             stop,
   output logic             busy,
   output logic             mic_clk,
   output logic             mic_lrsel,
   input  logic             mic_data,
   output logic [PCM_W-1:0] pcm_data,
   output logic             pcm_valid,
   input  logic             pcm_ready,
   output logic             overflow
);
   localparam int unsigned DIV_W = cnt_width(HALF_PERIOD);
   localparam int unsigned BIT_W = cnt_width(DECIM);
   localparam int unsigned DSC_W = cnt_width(WARMUP);

   state_e           state_q, state_d;
   logic [DIV_W-1:0] div_q;
   logic             mic_clk_q, strobe_q;
   logic [1:0]       sync_q;
   logic [BIT_W-1:0] bit_cnt_q;
   logic [PCM_W-1:0] acc_q, sample, push_data;
   logic [DSC_W-1:0] discard_q, discard_d;
   logic             stop_pend_q, stop_pend_d, overflow_q;
   logic             fall, frame_done, push, accept, fifo_full;

   // Strobe is registered so it lands in the cycle mic_clk has just gone low.
   assign fall       = (state_q != ST_IDLE) && mic_clk_q && (div_q == '0);
   assign frame_done = strobe_q && (bit_cnt_q == BIT_W'(DECIM - 1));
   assign sample     = acc_q + PCM_W'(sync_q[1]);
   assign busy       = (state_q != ST_IDLE);
   assign mic_clk    = mic_clk_q;
   assign mic_lrsel  = 1'b0;
   assign overflow   = overflow_q;

`ifdef PDM_CAP_SIGNED_OUT_EN
   assign push_data = sample - PCM_W'(DECIM / 2);
`else
   assign push_data = sample;
`endif

   always_comb begin
      state_d     = state_q;
      discard_d   = discard_q;
      stop_pend_d = stop_pend_q;
      push        = 1'b0;
      accept      = 1'b0;
      unique case (state_q)
         ST_IDLE: begin
            if (start) begin
               accept      = 1'b1;
               state_d     = (WARMUP == 0) ? ST_RUN : ST_WARMUP;
               discard_d   = '0;
               stop_pend_d = 1'b0;
            end
         end
         ST_WARMUP: begin
            if (stop) stop_pend_d = 1'b1;
            if (frame_done) begin
               if (stop_pend_q || stop) begin
                  state_d     = ST_IDLE;
                  stop_pend_d = 1'b0;
               end else if (int'(discard_q) == int'(WARMUP) - 1) begin
                  state_d = ST_RUN;
               end else begin
                  discard_d = discard_q + 1'b1;
               end
            end
         end
         ST_RUN: begin
            if (stop) stop_pend_d = 1'b1;
            if (frame_done) begin
               push = 1'b1;
               if (stop_pend_q || stop) begin
                  state_d     = ST_IDLE;
                  stop_pend_d = 1'b0;
               end
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= ST_IDLE;
         discard_q   <= '0;
         stop_pend_q <= 1'b0;
         overflow_q  <= 1'b0;
      end else begin
         state_q     <= state_d;
         discard_q   <= discard_d;
         stop_pend_q <= stop_pend_d;
         if (accept) begin
            overflow_q <= 1'b0;
         end else if (push && fifo_full && !pcm_ready) begin
            overflow_q <= 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         div_q     <= '0;
         mic_clk_q <= 1'b0;
         strobe_q  <= 1'b0;
         sync_q    <= '0;
         bit_cnt_q <= '0;
         acc_q     <= '0;
      end else begin
         sync_q   <= {sync_q[0], mic_data};
         strobe_q <= fall;
         if (accept) begin
            div_q     <= DIV_W'(HALF_PERIOD - 1);
            mic_clk_q <= 1'b0;
            bit_cnt_q <= '0;
            acc_q     <= '0;
         end else if (state_q != ST_IDLE) begin
            if (div_q == '0) begin
               div_q     <= DIV_W'(HALF_PERIOD - 1);
               mic_clk_q <= ~mic_clk_q;
            end else begin
               div_q <= div_q - 1'b1;
            end
            if (strobe_q) begin
               if (frame_done) begin
                  bit_cnt_q <= '0;
                  acc_q     <= '0;
               end else begin
                  bit_cnt_q <= bit_cnt_q + 1'b1;
                  acc_q     <= sample;
               end
            end
         end
      end
   end

   pdm_cap_fifo #(
      .DEPTH (FIFO_DEPTH),
      .W     (PCM_W)
   ) u_fifo (
      .clk         (clk),
      .reset       (reset),
      .push_i      (push),
      .push_data_i (push_data),
      .full_o      (fifo_full),
      .pop_i       (pcm_ready),
      .head_o      (pcm_data),
      .valid_o     (pcm_valid)
   );

endmodule

// File: tb/tb_pdm_capture_ctrl.sv
// Self-checking bench for pdm_capture_ctrl: randomized mic data against a
// frame-level ones-counting model with a bounded expected-sample queue.
module tb_pdm_capture_ctrl;
   localparam int HP    = 4;
   localparam int DEC   = 8;
   localparam int WU    = 1;
   localparam int FD    = 4;
   localparam int PW    = 4;
   localparam int FRAME = 2 * HP * DEC;

   logic          clk = 1'b0;
   logic          reset, start, stop, mic_data, pcm_ready;
   logic          busy, mic_clk, mic_lrsel, pcm_valid, overflow;
   logic [PW-1:0] pcm_data;

   int            n_tests = 0;
   int            n_fail  = 0;
   int            mode;          // 0: constant 1, 1: alternating, 2: random
   logic          alt_bit, drv_bit, exp_ovf;
   int            rise_cnt, ones, pop_cnt;
   logic [PW-1:0] exp_q [$];

   always #5 clk = ~clk;

   pdm_capture_ctrl #(
      .HALF_PERIOD (HP),
      .DECIM       (DEC),
      .WARMUP      (WU),
      .FIFO_DEPTH  (FD)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .start     (start),
      .stop      (stop),
      .busy      (busy),
      .mic_clk   (mic_clk),
      .mic_lrsel (mic_lrsel),
      .mic_data  (mic_data),
      .pcm_data  (pcm_data),
      .pcm_valid (pcm_valid),
      .pcm_ready (pcm_ready),
      .overflow  (overflow)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   function automatic logic [PW-1:0] to_pcm(input int n_ones);
`ifdef PDM_CAP_SIGNED_OUT_EN
      return PW'(n_ones - DEC / 2);
`else
      return PW'(n_ones);
`endif
   endfunction

   // Mic model: one new bit per mic_clk period; every DEC bits form one frame.
   always @(posedge mic_clk) begin
      #1;
      case (mode)
         0:       drv_bit = 1'b1;
         1:       begin alt_bit = ~alt_bit; drv_bit = alt_bit; end
         default: drv_bit = 1'($urandom_range(0, 1));
      endcase
      mic_data = drv_bit;
      ones += int'(drv_bit);
      rise_cnt++;
      if (rise_cnt % DEC == 0) begin
         if (rise_cnt / DEC > WU) begin
            if (exp_q.size() < FD) exp_q.push_back(to_pcm(ones));
            else exp_ovf = 1'b1;
         end
         ones = 0;
      end
   end

   always @(negedge clk) begin
      if (!reset && pcm_valid && pcm_ready) begin
         pop_cnt++;
         if (exp_q.size() == 0) check("pcm_extra_sample", exp_q.size(), 1);
         else check("pcm_data", pcm_data, exp_q.pop_front());
      end
   end

   task automatic do_start(input logic with_stop);
      @(posedge clk); #1;
      rise_cnt = 0;
      ones     = 0;
      exp_ovf  = 1'b0;
      alt_bit  = 1'b0;
      start    = 1'b1;
      stop     = with_stop;
      @(posedge clk); #1;
      start = 1'b0;
      stop  = 1'b0;
   endtask

   task automatic pulse_stop_and_wait_idle();
      logic idle;
      @(posedge clk); #1 stop = 1'b1;
      @(posedge clk); #1 stop = 1'b0;
      idle = 1'b0;
      for (int n = 0; n < 3 * FRAME; n++) begin
         @(posedge clk); #1;
         if (!busy) begin idle = 1'b1; break; end
      end
      check("idle_after_stop", idle, 1'b1);
   endtask

   task automatic check_reset_values(input string tag);
      check({tag, "_busy"},      busy, 0);
      check({tag, "_mic_clk"},   mic_clk, 0);
      check({tag, "_pcm_valid"}, pcm_valid, 0);
      check({tag, "_pcm_data"},  pcm_data, 0);
      check({tag, "_overflow"},  overflow, 0);
   endtask

   initial begin
      int first_rise, first_valid, t_a, t_b, t_fall, pc0;
      reset = 1'b1; start = 1'b0; stop = 1'b0; mic_data = 1'b0; pcm_ready = 1'b1;
      mode = 0; alt_bit = 1'b0; drv_bit = 1'b0; exp_ovf = 1'b0;
      rise_cnt = 0; ones = 0; pop_cnt = 0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check_reset_values("reset");
      check("mic_lrsel", mic_lrsel, 0);
      reset = 1'b0;

      // Stop in IDLE is ignored.
      @(posedge clk); #1 stop = 1'b1;
      @(posedge clk); #1 stop = 1'b0;
      repeat (5) @(posedge clk);
      #1;
      check("idle_stop_busy", busy, 0);
      check("idle_stop_mic_clk", mic_clk, 0);

      // Constant ones: first mic_clk rise and first RUN sample latency.
      mode = 0;
      do_start(1'b0);
      first_rise = -1; first_valid = -1;
      for (int n = 1; n <= 3 * FRAME && first_valid < 0; n++) begin
         @(posedge clk); #1;
         if (first_rise < 0 && mic_clk) first_rise = n;
         if (first_valid < 0 && pcm_valid) begin
            first_valid = n;
            check("first_pcm_data", pcm_data, to_pcm(DEC));
         end
      end
      check("first_mic_clk_rise", first_rise, HP);
      check("first_pcm_valid", first_valid, (WU + 1) * FRAME + 1);

      // Alternating bits: every sample is half scale, one per frame.
      mode = 1;
      t_a = -1; t_b = -1;
      for (int n = 1; n <= 2 * FRAME; n++) begin
         @(posedge clk); #1;
         if (pcm_valid) begin t_a = n; check("alt_sample_a", pcm_data, to_pcm(DEC / 2)); break; end
      end
      for (int n = 1; n <= 2 * FRAME; n++) begin
         @(posedge clk); #1;
         if (pcm_valid) begin t_b = n; check("alt_sample_b", pcm_data, to_pcm(DEC / 2)); break; end
      end
      check("alt_seen", (t_a > 0) && (t_b > 0), 1);
      check("alt_interval", t_b, FRAME);

      // Back-pressure: FIFO fills, extra samples dropped, overflow sticks.
      mode = 2;
      pcm_ready = 1'b0;
      repeat (6 * FRAME + 8) @(posedge clk);
      #1;
      check("overflow_set", overflow, 1);
      check("overflow_model", overflow, exp_ovf);
      check("full_valid", pcm_valid, 1);
      pulse_stop_and_wait_idle();
      pc0 = pop_cnt;
      pcm_ready = 1'b1;
      repeat (10) @(posedge clk);
      #1;
      check("drain_count", pop_cnt - pc0, FD);
      check("drain_empty", pcm_valid, 0);
      check("overflow_sticky_idle", overflow, 1);

      // Restart clears overflow; stop mid-frame completes that frame.
      do_start(1'b0);
      check("overflow_cleared", overflow, 0);
      pc0 = pop_cnt; t_fall = -1;
      for (int n = 1; n <= 5 * FRAME && t_fall < 0; n++) begin
         @(posedge clk); #1;
         stop = (n == 2 * FRAME + 20);
         if (!busy) begin
            t_fall = n;
            check("stop_mic_clk_low", mic_clk, 0);
            check("stop_last_valid", pcm_valid, 1);
         end
      end
      stop = 1'b0;
      check("stop_busy_fall", t_fall, 3 * FRAME + 1);
      repeat (4) @(posedge clk);
      #1;
      check("stop_sample_count", pop_cnt - pc0, 2);

      // Reset mid-RUN with samples held in the FIFO.
      do_start(1'b0);
      pcm_ready = 1'b0;
      repeat (3 * FRAME + 30) @(posedge clk);
      #1;
      check("pre_reset_valid", pcm_valid, 1);
      @(negedge clk);
      reset = 1'b1;
      exp_q.delete();
      @(posedge clk); #1;
      check_reset_values("mid_reset");
      @(negedge clk);
      reset = 1'b0;
      pcm_ready = 1'b1;
      repeat (5) @(posedge clk);
      #1;
      check("post_reset_empty", pcm_valid, 0);
      check("post_reset_idle", busy, 0);

      // start and stop together in IDLE: start wins, capture continues.
      do_start(1'b1);
      check("start_stop_busy", busy, 1);
      repeat (2 * FRAME + 10) @(posedge clk);
      #1;
      check("start_stop_still_busy", busy, 1);
      pulse_stop_and_wait_idle();
      repeat (5) @(posedge clk);
      #1;
      check("model_drained", exp_q.size(), 0);
      check("final_overflow", overflow, exp_ovf);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
